// File: rtl/bcd_update_arb_if.sv
// Request/display bundle for the shared binary-to-BCD converter.
// The requester side is master; the converter is slave.
interface bcd_update_arb_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_data;
  logic [WIDTH-1:0] req1_data;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             disp_src;
  logic             busy;
  logic             done;

  modport master (
    output req_valid, req0_data, req1_data,
    input  req_ready, hundreds, tens, ones,
    input  disp_src, busy, done
  );

  modport slave (
    input  req_valid, req0_data, req1_data,
    output req_ready, hundreds, tens, ones,
    output disp_src, busy, done
  );
endinterface

// File: rtl/bcd_update_arb.sv
// Round-robin shared double-dabble converter driving 3 display digits,
// with a hold window after each commit to rate-limit updates.
module bcd_update_arb #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 27000
) (
  input logic            clk,
  input logic            rst,
  bcd_update_arb_if.slave bus
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh;
  logic [11:0]      scr;
  logic [11:0]      adj;
  logic [3:0]       bit_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             src;
  logic             last_grant;
  logic             gnt;
  logic [1:0]       ready;
  logic             xfer;
  logic [3:0]       hundreds_q;
  logic [3:0]       tens_q;
  logic [3:0]       ones_q;
  logic             disp_src_q;
  logic             done_q;
  logic             unused_adj;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    gnt   = bus.req_valid[1];
    ready = 2'b00;
    if (bus.req_valid == 2'b11) begin
      gnt = ~last_grant;
    end
    if (state == IDLE) begin
      if (bus.req_valid == 2'b11) begin
        ready = gnt ? 2'b10 : 2'b01;
      end else begin
        ready = bus.req_valid;
      end
    end
    xfer = |ready;
  end

  always_comb begin
    adj = scr;
    for (int k = 0; k < 3; k++) begin
      if (scr[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
      end
    end
  end

  assign unused_adj = adj[11];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (xfer) state_nxt = SHIFT;
      SHIFT:  if (bit_cnt == 4'd1) state_nxt = COMMIT;
      COMMIT: state_nxt = HOLD;
      HOLD:   if (hold_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      scr        <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      src        <= 1'b0;
      last_grant <= 1'b1;
      hundreds_q <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      disp_src_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == COMMIT);
      unique case (state)
        IDLE: begin
          if (xfer) begin
            sh         <= gnt ? bus.req1_data : bus.req0_data;
            scr        <= '0;
            bit_cnt    <= 4'(WIDTH);
            src        <= gnt;
            last_grant <= gnt;
          end
        end
        SHIFT: begin
          {scr, sh} <= {adj[10:0], sh, 1'b0};
          bit_cnt   <= bit_cnt - 4'd1;
        end
        COMMIT: begin
          hundreds_q <= scr[11:8];
          tens_q     <= scr[7:4];
          ones_q     <= scr[3:0];
          disp_src_q <= src;
          hold_cnt   <= HW'(HOLD_CYCLES - 1);
        end
        HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.hundreds  = hundreds_q;
  assign bus.tens      = tens_q;
  assign bus.ones      = ones_q;
  assign bus.disp_src  = disp_src_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_bcd_update_arb.sv
// Bench for bcd_update_arb: directed and random requests checked
// against an arithmetic digit model and a round-robin grant model.
module tb_bcd_update_arb;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_update_arb_if #(.WIDTH(W)) bus ();

  bcd_update_arb #(
    .WIDTH      (W),
    .HOLD_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic       lg;
  logic [3:0] mh;
  logic [3:0] mt;
  logic [3:0] mo;
  logic       msrc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_digits(input string tag);
    chk(tag, {20'd0, bus.hundreds, bus.tens, bus.ones}, {20'd0, mh, mt, mo});
  endtask

  task automatic accept(input logic [1:0] v, input logic [7:0] d0,
                        input logic [7:0] d1, output int val, output int g);
    int n;
    n = 0;
    bus.req_valid = v;
    bus.req0_data = d0;
    bus.req1_data = d1;
    #1;
    while (bus.req_ready == 2'b00 && n < 40) begin
      step();
      #1;
      n++;
    end
    chk("accept_timeout", 32'(n < 40), 32'd1);
    g = (v == 2'b11) ? int'(!lg) : int'(v[1]);
    chk("req_ready", 32'(bus.req_ready), (g == 1) ? 32'd2 : 32'd1);
    val = (g == 1) ? int'(d1) : int'(d0);
    lg  = g[0];
    step();
  endtask

  task automatic xact(input logic [1:0] v, input logic [7:0] d0,
                      input logic [7:0] d1, input logic [1:0] next_v);
    int val;
    int g;
    accept(v, d0, d1, val, g);
    bus.req_valid = next_v;
    #1;
    for (int i = 0; i <= W; i++) begin
      chk("conv_ready_busy_done", {29'd0, bus.req_ready, bus.busy, bus.done},
          {29'd0, 2'b00, 1'b1, 1'b0});
      chk_digits("conv_digits_stable");
      step();
    end
    mh   = 4'(val / 100);
    mt   = 4'((val / 10) % 10);
    mo   = 4'(val % 10);
    msrc = g[0];
    chk_digits("commit_digits");
    chk("commit_done", 32'(bus.done), 32'd1);
    chk("commit_src", 32'(bus.disp_src), 32'(msrc));
    chk("hold_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("post_done_low", 32'(bus.done), 32'd0);
    chk_digits("idle_digits");
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int val;
    int g;
    logic [7:0] bnd [6];
    bnd = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd200};

    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req0_data = '0;
    bus.req1_data = '0;
    lg = 1'b1; mh = 0; mt = 0; mo = 0; msrc = 1'b0;
    step();
    step();
    chk_digits("reset_digits");
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_src", 32'(bus.disp_src), 32'd0);
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    step();

    xact(2'b01, 8'd255, 8'd0, 2'b00);

    for (int i = 0; i < 6; i++) begin
      xact(2'b11, 8'd123, 8'd45, (i == 5) ? 2'b00 : 2'b11);
    end

    foreach (bnd[i]) xact(2'b01, bnd[i], 8'd0, 2'b00);

    xact(2'b01, 8'd77, 8'd200, 2'b10);
    xact(2'b10, 8'd77, 8'd200, 2'b00);

    accept(2'b01, 8'd50, 8'd0, val, g);
    bus.req_valid = 2'b00;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    lg = 1'b1; mh = 0; mt = 0; mo = 0; msrc = 1'b0;
    chk_digits("rst_mid_digits");
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("rst_no_done", 32'(bus.done), 32'd0);
      chk_digits("rst_digits_hold");
    end
    xact(2'b11, 8'd42, 8'd99, 2'b00);

    for (int i = 0; i < 256; i++) begin
      xact(2'b01, 8'(i), 8'd0, 2'b00);
      xact(2'b10, 8'd0, 8'(i), 2'b00);
    end

    repeat (150) begin
      xact(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
